screen_sequencer: RTL and testbench

// - Top-level game-screen controller. Sequences START -> PLAY -> LEVEL-CLEAR -> GAME-OVER.
// - Drives the 2-bit `message` select shared by the screen bitmaps (00 = start screen, 01 = playing,
//   10 = level cleared, 11 = game over).
// - Also drives the start-text blink gate, the level index and the game-run/load strobes to the game core.
// - Sits between the keyboard/collision logic and the screen bitmaps; timing is counted in video frames.

---
 rtl/screen_sequencer.sv | 95 +++++++++
 tb/tb_screen_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/screen_sequencer.sv
// screen_sequencer: frame-timed START/PLAY/LEVEL/OVER screen controller driving bitmaps and game core
module screen_sequencer #(
  parameter int BLINK_FRAMES        = 30,
  parameter int LEVEL_SCREEN_FRAMES = 120,
  parameter int OVER_SCREEN_FRAMES  = 180,
  parameter int NUM_LEVELS          = 3,
  parameter int LEVEL_W             = 2
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               keyStart,
  input  logic               levelCleared,
  input  logic               livesZero,
  output logic [1:0]         message,
  output logic               gameRun,
  output logic               levelLoad,
  output logic               newGame,
  output logic [LEVEL_W-1:0] level,
  output logic               blinkOn,
  output logic               playerWon
);
  localparam int MAX_BL = BLINK_FRAMES > LEVEL_SCREEN_FRAMES ? BLINK_FRAMES : LEVEL_SCREEN_FRAMES;
  localparam int MAX_F  = MAX_BL > OVER_SCREEN_FRAMES ? MAX_BL : OVER_SCREEN_FRAMES;
  localparam int CW     = $clog2(MAX_F + 1);
  typedef enum logic [1:0] {S_START = 2'b00, S_PLAY = 2'b01, S_LEVEL = 2'b10, S_OVER = 2'b11} state_t;
  state_t        state;
  logic [CW-1:0] frame_cnt;
  assign message = state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_START;
      gameRun   <= 1'b0;
      levelLoad <= 1'b0;
      newGame   <= 1'b0;
      level     <= '0;
      blinkOn   <= 1'b1;
      playerWon <= 1'b0;
      frame_cnt <= '0;
    end else begin
      levelLoad <= 1'b0;
      newGame   <= 1'b0;
      case (state)
        S_START: begin
          if (keyStart) begin
            state     <= S_PLAY;
            level     <= '0;
            playerWon <= 1'b0;
            newGame   <= 1'b1;
            levelLoad <= 1'b1;
            gameRun   <= 1'b1;
            blinkOn   <= 1'b1;
            frame_cnt <= '0;
          end else if (startOfFrame) begin
            blinkOn   <= frame_cnt == CW'(BLINK_FRAMES - 1) ? ~blinkOn : blinkOn;
            frame_cnt <= frame_cnt == CW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
          end
        end
        // livesZero outranks levelCleared; the counter stays at 0 throughout play
        S_PLAY: begin
          frame_cnt <= '0;
          if (livesZero) begin
            state     <= S_OVER;
            playerWon <= 1'b0;
            gameRun   <= 1'b0;
          end else if (levelCleared) begin
            state     <= level == LEVEL_W'(NUM_LEVELS - 1) ? S_OVER : S_LEVEL;
            playerWon <= level == LEVEL_W'(NUM_LEVELS - 1);
            gameRun   <= 1'b0;
          end
        end
        S_LEVEL: begin
          if (startOfFrame && frame_cnt == CW'(LEVEL_SCREEN_FRAMES - 1)) begin
            state     <= S_PLAY;
            level     <= level + 1'b1;
            levelLoad <= 1'b1;
            gameRun   <= 1'b1;
            frame_cnt <= '0;
          end else if (startOfFrame) begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: begin
          if (startOfFrame && frame_cnt == CW'(OVER_SCREEN_FRAMES - 1)) begin
            state     <= S_START;
            blinkOn   <= 1'b1;
            frame_cnt <= '0;
          end else if (startOfFrame) begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed plus random stimulus checked against a frame-counting screen model
module tb_screen_sequencer;
  localparam int B = 30, LS = 120, OS = 180, N = 3;
  logic clk = 1'b0, reset = 1'b1, sof = 1'b0, ks = 1'b0, lc = 1'b0, lz = 1'b0;
  logic [1:0] message;
  logic game_run, level_load, new_game, blink_on, player_won;
  logic [1:0] level;
  int errors = 0, checks = 0;
  int m_scr = 0, m_fr = 0, m_lvl = 0;
  bit m_blink = 1, m_won = 0, m_ng = 0, m_ll = 0, armed = 0;

  screen_sequencer #(.BLINK_FRAMES(B), .LEVEL_SCREEN_FRAMES(LS), .OVER_SCREEN_FRAMES(OS),
                     .NUM_LEVELS(N), .LEVEL_W(2)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .keyStart(ks), .levelCleared(lc),
    .livesZero(lz), .message(message), .gameRun(game_run), .levelLoad(level_load),
    .newGame(new_game), .level(level), .blinkOn(blink_on), .playerWon(player_won));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: screens as integers, blink derived from frames elapsed since entering START
  always @(posedge clk) begin
    m_ng = 0;
    m_ll = 0;
    if (reset) begin
      m_scr = 0; m_lvl = 0; m_blink = 1; m_won = 0; m_fr = 0; armed = 1;
    end else if (m_scr == 0) begin
      if (ks) begin
        m_scr = 1; m_lvl = 0; m_won = 0; m_ng = 1; m_ll = 1; m_blink = 1;
      end else if (sof) begin
        m_fr++;
        m_blink = ((m_fr / B) % 2) == 0;
      end
    end else if (m_scr == 1) begin
      if (lz) begin
        m_scr = 3; m_won = 0; m_fr = 0;
      end else if (lc) begin
        m_won = (m_lvl == N - 1);
        m_scr = m_won ? 3 : 2;
        m_fr = 0;
      end
    end else if (sof) begin
      m_fr++;
      if (m_scr == 2 && m_fr == LS) begin
        m_scr = 1; m_lvl++; m_ll = 1;
      end else if (m_scr == 3 && m_fr == OS) begin
        m_scr = 0; m_blink = 1; m_fr = 0;
      end
    end
    #1;
    if (armed) begin
      chk("message", message, m_scr);
      chk("gameRun", game_run, m_scr == 1);
      chk("levelLoad", level_load, m_ll);
      chk("newGame", new_game, m_ng);
      chk("level", level, m_lvl);
      chk("blinkOn", blink_on, m_blink);
      if (m_scr == 3) chk("playerWon", player_won, m_won);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      sof = 1; step(); sof = 0; step();
    end
  endtask

  task automatic pulse_ks(); ks = 1; step(); ks = 0; endtask
  task automatic pulse_lc(); lc = 1; step(); lc = 0; endtask

  initial begin
    step();
    reset = 0;
    chk("rst_message", message, 2'b00);
    chk("rst_blink", blink_on, 1);
    chk("rst_run", game_run, 0);
    chk("rst_level", level, 0);
    frames(B - 1);
    chk("blink_29", blink_on, 1);
    frames(1);
    chk("blink_30", blink_on, 0);
    frames(B);
    chk("blink_60", blink_on, 1);
    chk("start_msg", message, 2'b00);
    pulse_ks();
    chk("play_msg", message, 2'b01);
    chk("play_run", game_run, 1);
    chk("play_ng", new_game, 1);
    chk("play_ll", level_load, 1);
    step();
    chk("play_ng_drop", new_game, 0);
    pulse_lc();
    chk("lvl_msg", message, 2'b10);
    chk("lvl_run", game_run, 0);
    frames(LS - 1);
    chk("lvl_hold", message, 2'b10);
    sof = 1; step(); sof = 0;
    chk("lvl_back_msg", message, 2'b01);
    chk("lvl_back_level", level, 1);
    chk("lvl_back_ll", level_load, 1);
    step();
    pulse_lc();
    frames(LS);
    chk("level2", level, 2);
    pulse_lc();
    chk("won_msg", message, 2'b11);
    chk("won_flag", player_won, 1);
    pulse_ks();
    chk("over_ks_ignored", message, 2'b11);
    frames(OS);
    chk("over_done_msg", message, 2'b00);
    chk("over_done_blink", blink_on, 1);
    pulse_ks();
    lz = 1; lc = 1; step(); lz = 0; lc = 0;
    chk("lz_prio_msg", message, 2'b11);
    chk("lz_prio_won", player_won, 0);
    chk("lz_prio_level", level, 0);
    frames(OS);
    pulse_ks();
    pulse_ks();
    chk("play_ks_ignored", message, 2'b01);
    pulse_lc();
    frames(50);
    reset = 1; step(); reset = 0;
    chk("midrst_msg", message, 2'b00);
    chk("midrst_level", level, 0);
    chk("midrst_run", game_run, 0);
    for (int i = 0; i < 20000; i++) begin
      reset = ($urandom % 700) == 0;
      sof = ($urandom % 2) == 0;
      ks = ($urandom % 25) == 0;
      lc = ($urandom % 30) == 0;
      lz = ($urandom % 60) == 0;
      step();
    end
    reset = 0; sof = 0; ks = 0; lc = 0; lz = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
